// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM-subset control FSM with ALU decode, flag register and condition check
module mc_control_unit #(
  parameter int ALUC_W  = 2,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        ALUFlags,
  input  logic              MemRdy,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [3:0]        State
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  state_t state, next;
  logic [3:0] flags;
  logic [3:0] cmd;
  logic [1:0] flagw;
  logic [ALUC_W-1:0] aluc_dec;
  logic condexr, condex, nowrite, stall, n, z, c, v;
  assign {n, z, c, v} = flags;
  assign cmd = Funct[4:1];
  assign stall = WAIT_EN && !MemRdy;
  always_comb begin
    case (Cond)
      4'b0000: condex = z;
      4'b0001: condex = !z;
      4'b0010: condex = c;
      4'b0011: condex = !c;
      4'b0100: condex = n;
      4'b0101: condex = !n;
      4'b0110: condex = v;
      4'b0111: condex = !v;
      4'b1000: condex = c && !z;
      4'b1001: condex = !c || z;
      4'b1010: condex = n == v;
      4'b1011: condex = n != v;
      4'b1100: condex = !z && (n == v);
      4'b1101: condex = z || (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end
  always_comb begin
    nowrite = 1'b0;
    aluc_dec = '0;
    case (cmd)
      4'b0100: aluc_dec = ALUC_W'(0);
      4'b0010: aluc_dec = ALUC_W'(1);
      4'b0000: aluc_dec = ALUC_W'(2);
      4'b1100: aluc_dec = ALUC_W'(3);
      4'b1010: begin
        aluc_dec = ALUC_W'(1);
        nowrite = 1'b1;
      end
      4'b0001: aluc_dec = ALUC_W >= 3 ? ALUC_W'(4) : ALUC_W'(2);
      default: nowrite = 1'b1;
    endcase
  end
  // CMP always updates all four flags, even with S clear
  assign flagw = cmd == 4'b1010 ? 2'b11 :
                 {Funct[0], Funct[0] && (cmd == 4'b0100 || cmd == 4'b0010)};
  always_comb begin
    case (state)
      FETCH:   next = stall ? FETCH : DECODE;
      DECODE:  next = Op == 2'b01 ? MEMADR :
                      Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                      Op == 2'b10 ? BRANCH : FETCH;
      MEMADR:  next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: next = stall ? MEMREAD : MEMWB;
      EXECR:   next = ALUWB;
      EXECI:   next = ALUWB;
      default: next = FETCH;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
      flags <= '0;
      condexr <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) condexr <= condex;
      if (state == ALUWB && condexr && flagw[1]) flags[3:2] <= ALUFlags[3:2];
      if (state == ALUWB && condexr && flagw[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end
  always_comb begin
    PCWrite = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcB = 2'b00;
    ALUControl = '0;
    ImmSrc = Op;
    RegSrc = {Op == 2'b01, Op == 2'b10};
    State = state;
    case (state)
      FETCH: begin
        // reset holds the FSM here, so gating these strobes keeps all writes quiet during RST
        IRWrite = !stall && !RST;
        PCWrite = !stall && !RST;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite = condexr;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemWrite = condexr;
      end
      EXECR: ALUControl = aluc_dec;
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUControl = aluc_dec;
      end
      ALUWB: begin
        RegWrite = condexr && !nowrite;
        PCWrite = condexr && !nowrite && Rd == 4'd15;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        PCWrite = condexr;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed ARM instruction sequences against two parameterisations and a behavioural model
module tb_mc_control_unit;
  logic CLK = 1'b0, RST;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic MemRdy;
  logic pcw0, rw0, mw0, irw0, adr0, asa0, pcw1, rw1, mw1, irw1, adr1, asa1;
  logic [1:0] rs0, asb0, imm0, rsrc0, rs1, asb1, imm1, rsrc1, alu0;
  logic [2:0] alu1;
  logic [3:0] st0, st1;
  logic [20:0] d0, d1, e0, e1;
  int tests = 0, fails = 0;
  bit done = 0;
  int ms [2];
  logic [3:0] mf [2];
  bit mc [2];
  bit we [2] = '{1'b1, 1'b0};
  int aw [2] = '{2, 3};

  mc_control_unit #(.ALUC_W(2), .WAIT_EN(1'b1)) u0 (
    .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemRdy(MemRdy), .PCWrite(pcw0), .RegWrite(rw0),
    .MemWrite(mw0), .IRWrite(irw0), .AdrSrc(adr0), .ALUSrcA(asa0),
    .ResultSrc(rs0), .ALUSrcB(asb0), .ImmSrc(imm0), .RegSrc(rsrc0),
    .ALUControl(alu0), .State(st0));
  mc_control_unit #(.ALUC_W(3), .WAIT_EN(1'b0)) u1 (
    .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemRdy(MemRdy), .PCWrite(pcw1), .RegWrite(rw1),
    .MemWrite(mw1), .IRWrite(irw1), .AdrSrc(adr1), .ALUSrcA(asa1),
    .ResultSrc(rs1), .ALUSrcB(asb1), .ImmSrc(imm1), .RegSrc(rsrc1),
    .ALUControl(alu1), .State(st1));

  assign d0 = {st0, pcw0, rw0, mw0, irw0, adr0, asa0, rs0, asb0, imm0, rsrc0, 1'b0, alu0};
  assign d1 = {st1, pcw1, rw1, mw1, irw1, adr1, asa1, rs1, asb1, imm1, rsrc1, alu1};

  always #5 CLK = ~CLK;

  // condition codes come in true/inverted pairs selected by Cond[0]
  function automatic bit cond_ok(logic [3:0] cd, logic [3:0] f);
    bit n, z, c, v, b;
    {n, z, c, v} = f;
    case (cd[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c && !z;
      3'd5: b = n == v;
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return cd == 4'hf ? 1'b0 : cd == 4'he ? 1'b1 : b ^ cd[0];
  endfunction

  function automatic int alu_code(logic [3:0] cmd, int w);
    if (cmd == 4'b0010 || cmd == 4'b1010) return 1;
    if (cmd == 4'b0000) return 2;
    if (cmd == 4'b1100) return 3;
    if (cmd == 4'b0001) return w == 3 ? 4 : 2;
    return 0;
  endfunction

  function automatic bit no_write(logic [3:0] cmd);
    return !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001});
  endfunction

  function automatic logic [3:0] upd_flags(logic [3:0] f);
    bit cmp, hi, lo;
    cmp = Funct[4:1] == 4'b1010;
    hi = cmp || Funct[0];
    lo = cmp || (Funct[0] && Funct[4:1] inside {4'b0100, 4'b0010});
    return {hi ? ALUFlags[3:2] : f[3:2], lo ? ALUFlags[1:0] : f[1:0]};
  endfunction

  function automatic int next_st(int st, bit w);
    bit stl = w && !MemRdy;
    case (st)
      0: return stl ? 0 : 1;
      1: return Op == 2'b01 ? 2 : Op == 2'b00 ? (Funct[5] ? 7 : 6) : Op == 2'b10 ? 9 : 0;
      2: return Funct[0] ? 3 : 5;
      3: return stl ? 3 : 4;
      6, 7: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [20:0] model_out(int k);
    int st, code;
    bit stl, wr, pcw, rw, mw, irw, adr, asa;
    logic [1:0] rs, asb;
    st = ms[k];
    stl = we[k] && !MemRdy;
    wr = mc[k] && !no_write(Funct[4:1]);
    irw = st == 0 && !stl && !RST;
    pcw = irw || (st == 9 && mc[k]) || (st == 8 && wr && Rd == 4'd15);
    rw = (st == 4 && mc[k]) || (st == 8 && wr);
    mw = st == 5 && mc[k];
    adr = st == 3 || st == 5;
    asa = st <= 1;
    asb = st <= 1 ? 2'b10 : (st == 2 || st == 7 || st == 9) ? 2'b01 : 2'b00;
    rs = (st <= 1 || st == 9) ? 2'b10 : st == 4 ? 2'b01 : 2'b00;
    code = (st == 6 || st == 7) ? alu_code(Funct[4:1], aw[k]) : 0;
    return {4'(st), pcw, rw, mw, irw, adr, asa, rs, asb, Op, Op == 2'b01, Op == 2'b10, 3'(code)};
  endfunction

  always @(posedge CLK or posedge RST)
    for (int k = 0; k < 2; k++)
      if (RST) begin
        ms[k] <= 0;
        mf[k] <= 4'b0000;
        mc[k] <= 1'b0;
      end else begin
        if (ms[k] == 1) mc[k] <= cond_ok(Cond, mf[k]);
        if (ms[k] == 8 && mc[k]) mf[k] <= upd_flags(mf[k]);
        ms[k] <= next_st(ms[k], we[k]);
      end

  always @(negedge CLK) if (!done) begin
    e0 = model_out(0);
    e1 = model_out(1);
    tests += 2;
    if (d0 !== e0) begin
      fails++;
      $display("FAIL cycle_u0 t=%0t got %h want %h", $time, d0, e0);
    end
    if (d1 !== e1) begin
      fails++;
      $display("FAIL cycle_u1 t=%0t got %h want %h", $time, d1, e1);
    end
  end

  task automatic chk(string nm, logic [7:0] a, logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set(logic [3:0] cd, logic [1:0] op, logic [5:0] fn, logic [3:0] rd, logic [3:0] fl);
    Cond = cd;
    Op = op;
    Funct = fn;
    Rd = rd;
    ALUFlags = fl;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    Cond = 4'he; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0; MemRdy = 1'b1;
    #12;
    chk("rst_state", st0, 0);
    chk("rst_strobes", {pcw0, rw0, mw0, irw0}, 0);
    RST = 1'b0;
    // ADDS R1 with flags 0110
    set(4'he, 2'b00, 6'b001001, 4'd1, 4'b0110);
    chk("add_fetch_st", st0, 0);
    chk("add_fetch_strobes", {irw0, pcw0}, 2'b11);
    cyc; chk("add_decode", st0, 1);
    cyc; chk("add_execr", st0, 6); chk("add_aluc", alu0, 0);
    cyc; chk("add_aluwb", st0, 8); chk("add_regwrite", rw0, 1);
    cyc; chk("add_done", st0, 0);
    // BEQ sees Z=1 from the ADD
    set(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
    cyc; cyc; chk("beq_branch", st0, 9); chk("beq_pcwrite", pcw0, 1);
    cyc;
    // EOR decode in both widths
    set(4'he, 2'b00, 6'b000010, 4'd4, 4'b1000);
    cyc; cyc; chk("eor_st", st0, 6); chk("eor_w2", alu0, 2'b10); chk("eor_w3", alu1, 3'b100);
    cyc; cyc;
    // CMP loads Z=1 without writing a register
    set(4'he, 2'b00, 6'b010101, 4'd0, 4'b0100);
    cyc; cyc; chk("cmp_aluc", alu0, 1);
    cyc; chk("cmp_regwrite", rw0, 0);
    cyc;
    set(4'h1, 2'b10, 6'd0, 4'd0, 4'd0);
    cyc; cyc; chk("bne_branch", st0, 9); chk("bne_pcwrite", pcw0, 0);
    cyc;
    // ADDSNE is skipped and must leave the flags alone
    set(4'h1, 2'b00, 6'b001001, 4'd5, 4'b1111);
    cyc; cyc; cyc; chk("addne_regwrite", rw0, 0);
    cyc;
    set(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
    cyc; cyc; chk("beq2_pcwrite", pcw0, 1);
    cyc;
    // ORR into R15 writes the PC
    set(4'he, 2'b00, 6'b011000, 4'd15, 4'd0);
    cyc; cyc; cyc; chk("orrpc_pcwrite", pcw0, 1); chk("orrpc_regwrite", rw0, 1);
    cyc;
    // LDR with a stalled fetch and a stalled read
    set(4'he, 2'b01, 6'b011001, 4'd2, 4'd0);
    MemRdy = 1'b0;
    #1 chk("fetch_stall", {irw0, pcw0}, 0);
    cyc; chk("fetch_hold", st0, 0);
    MemRdy = 1'b1;
    cyc; cyc; chk("ldr_memadr", st0, 2); chk("ldr_srcb", asb0, 2'b01);
    MemRdy = 1'b0;
    cyc;
    for (int i = 0; i < 3; i++) begin
      chk("ldr_wait", st0, 3);
      cyc;
    end
    chk("ldr_wait_last", st0, 3);
    MemRdy = 1'b1;
    cyc; chk("ldr_memwb", st0, 4); chk("ldr_regwrite", rw0, 1);
    cyc;
    // STR with Cond=never, then always
    set(4'hf, 2'b01, 6'b011000, 4'd0, 4'd0);
    cyc; cyc; cyc; chk("strnv_st", st0, 5); chk("strnv_memwrite", mw0, 0);
    cyc;
    set(4'he, 2'b01, 6'b011000, 4'd0, 4'd0);
    cyc; cyc; cyc; chk("str_memwrite", mw0, 1);
    cyc;
    // reset pulse in the middle of an EXECI
    set(4'he, 2'b00, 6'b100101, 4'd3, 4'b1111);
    cyc; cyc; chk("subi_execi", st0, 7);
    #2 RST = 1'b1;
    #1 chk("async_rst_state", st0, 0);
    chk("async_rst_strobes", {pcw0, rw0, mw0, irw0, pcw1, rw1, mw1, irw1}, 0);
    cyc; chk("rst_hold", st0, 0); chk("rst_hold_rw", rw0, 0);
    #2 RST = 1'b0;
    // flags were cleared, so BEQ falls through
    set(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
    cyc; cyc; chk("post_rst_branch", st0, 9); chk("post_rst_pcwrite", pcw0, 0);
    cyc; cyc;
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL have parameter ALUC_W, default 2, meaning ALUControl width: 2 gives ADD/SUB/AND/ORR; 3 adds EOR.
REQ-002 The block SHALL have parameter WAIT_EN, default 1, meaning 1 stalls FETCH and MEMREAD on MemRdy, and 0 ignores MemRdy.
REQ-003 The block SHALL have port CLK, input, width 1: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RST, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port Cond, input, width 4: instruction condition field [31:28].
REQ-006 The block SHALL have port Op, input, width 2: instruction [27:26]; 00 data-processing, 01 memory, 10 branch.
REQ-007 The block SHALL have port Funct, input, width 6: instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S or L.
REQ-008 The block SHALL have port Rd, input, width 4: destination register.
REQ-009 The block SHALL have port ALUFlags, input, width 4: {N,Z,C,V} from the ALU.
REQ-010 The block SHALL have port MemRdy, input, width 1: memory data valid this cycle.
REQ-011 The block SHALL have outputs PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc and ALUSrcA, each width 1.
REQ-012 The block SHALL have outputs ResultSrc, ALUSrcB, ImmSrc and RegSrc, each width 2, plus ALUControl, width ALUC_W.
REQ-013 The block SHALL have output State, width 4: current FSM state, for debug.

Function
REQ-014 The FSM SHALL have these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-015 FETCH SHALL assert IRWrite, AdrSrc=0, ALUSrcA=1, ALUSrcB=10 and ResultSrc=10 (PC+4), and assert PCWrite unconditionally.
REQ-016 With WAIT_EN=1 and MemRdy=0, FETCH SHALL hold state with IRWrite=0 and PCWrite=0.
REQ-017 DECODE SHALL set ALUSrcA=1, ALUSrcB=10 and ResultSrc=10.
REQ-018 DECODE SHALL register CondEx into CondExR.
REQ-019 DECODE SHALL branch on Op: 01 to MEMADR; 00 with Funct[5]=0 to EXECR; 00 with Funct[5]=1 to EXECI; 10 to BRANCH; 11 to FETCH (treated as NOP).
REQ-020 MEMADR SHALL set ALUSrcA=0, ALUSrcB=01 and ALUControl=ADD, then go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-021 MEMREAD SHALL set AdrSrc=1 and go to MEMWB when MemRdy=1 (or unconditionally when WAIT_EN=0).
REQ-022 MEMWB SHALL set ResultSrc=01 and RegWrite=CondExR, then go to FETCH.
REQ-023 MEMWRITE SHALL set AdrSrc=1 and MemWrite=CondExR, then go to FETCH; no MemRdy wait is applied.
REQ-024 EXECR SHALL set ALUSrcB=00; EXECI SHALL set ALUSrcB=01; both SHALL set ALUSrcA=0 and go to ALUWB.
REQ-025 ALUWB SHALL set ResultSrc=00 and RegWrite=CondExR and NoWrite=0.
REQ-026 When Rd=15 in ALUWB, PCWrite SHALL equal RegWrite.
REQ-027 BRANCH SHALL set ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10 and PCWrite=CondExR, then go to FETCH.
REQ-028 The ALU decode by cmd SHALL be: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 1010 CMP=SUB with NoWrite=1.
REQ-029 When ALUC_W=3, cmd 0001 SHALL decode to EOR=4; when ALUC_W=2, cmd 0001 SHALL decode as AND.
REQ-030 Any other cmd SHALL decode as ADD with NoWrite=1.
REQ-031 Control outputs SHALL be combinational from state and inputs; all unlisted outputs SHALL be 0 in each state.
REQ-032 ImmSrc SHALL equal Op and RegSrc SHALL equal {Op==01, Op==10} in every state.
REQ-033 FlagW[1] (N,Z) SHALL equal S for data-processing ops.
REQ-034 FlagW[0] (C,V) SHALL equal S and (ADD, SUB or CMP).
REQ-035 CMP SHALL force FlagW=11.
REQ-036 The flag register SHALL load ALUFlags at the end of ALUWB only for the enabled halves, and only when CondExR=1.
REQ-037 CondEx SHALL follow the ARM condition table over the flag register (EQ..LE); 1110 SHALL be always and 1111 never.
REQ-038 Flags captured at the end of one instruction SHALL be visible to the next instruction's DECODE.

Reset
REQ-039 RST=1 SHALL force State=FETCH, flags=0000 and CondExR=0 immediately, independent of CLK.
REQ-040 RST asserted mid-instruction SHALL abort it; no write strobe SHALL assert while RST=1.
REQ-041 The first FETCH SHALL occur on the first rising edge after RST deasserts.

Verification
REQ-042 ADD R1 with S=1 and ALUFlags=0110 -> states 0,1,6,8,0; RegWrite=1 in ALUWB; flags=0110 afterward.
REQ-043 CMP then BNE, with ALUFlags Z=1 from CMP -> CMP gives RegWrite=0 and flags Z=1; BNE reaches BRANCH with PCWrite=0.
REQ-044 LDR with WAIT_EN=1 and MemRdy low for 3 cycles in MEMREAD -> State holds at 3 for 3 cycles; MEMWB RegWrite=1.
REQ-045 STR with Cond=1111 -> MEMWRITE with MemWrite=0.
REQ-046 With ALUC_W=3, cmd 0001 gives ALUControl=100; with ALUC_W=2 it gives 10.
REQ-047 RST pulsed during EXECI -> State=0 asynchronously; flags=0000; no RegWrite pulse.
